// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read / 1-write ARM register file.
//   WIDTH    : data word width in bits
//   DEPTH    : number of architectural registers
//   ZERO_REG : index hard-wired to zero (XZR); writes to it are dropped
//   ADDR_W   : register index width, derived from DEPTH
//   NUM_IDX  : number of encodable indices (2**ADDR_W), which may exceed DEPTH
package regfile_pkg;

  localparam int WIDTH    = 64;
  localparam int DEPTH    = 32;
  localparam int ZERO_REG = 31;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int NUM_IDX  = 1 << ADDR_W;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  // An index has real storage only if it lies inside the file and is not XZR.
  function automatic bit is_storage(int idx);
    return (idx < DEPTH) && (idx != ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port of the register file.
//   clk, reset : clock and asynchronous active-high reset
//   rd_en      : capture enable; low holds rd_data (stall)
//   rd_addr    : register index to read
//   wr_en, wr_addr, wr_data : this cycle's write, used for same-edge bypass
//   mem_view   : current contents of every encodable index (0 where no storage)
//   readable   : 1 for indices backed by storage, 0 for XZR and out-of-range
//   rd_data    : registered read data
//   rd_valid   : 1 when rd_data was captured at the most recent edge
module regfile_rd_port
  import regfile_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en,
  input  reg_idx_t                  rd_addr,
  input  logic                      wr_en,
  input  reg_idx_t                  wr_addr,
  input  word_t                     wr_data,
  input  word_t [NUM_IDX-1:0]       mem_view,
  input  logic  [NUM_IDX-1:0]       readable,
  output word_t                     rd_data,
  output logic                      rd_valid
);

  word_t next_data;

  // Zero force covers XZR and out-of-range indices; it takes priority over the
  // bypass so a write aimed at XZR can never leak into a read of XZR.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves next_data
    // unassigned, which would infer a latch.
    next_data = '0;
    if (readable[rd_addr]) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        next_data = wr_data;
      end else begin
        next_data = mem_view[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge
      // values, independent of statement order across always_ff blocks.
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= next_data;
      end
    end
  end

endmodule

// File: rtl/regfile_read_2p.sv
// 32-entry, 64-bit ARM register file: one write port (from WB) and two
// registered read ports (Rn on A, Rm on B) feeding the ID/EX boundary.
// Reads capture on the clock edge with same-edge write bypass; X31 reads zero.
//   clk, reset             : clock and asynchronous active-high reset
//   wr_en, wr_addr, wr_data: write port
//   rd_en_a, rd_addr_a     : port A capture enable and index
//   rd_en_b, rd_addr_b     : port B capture enable and index
//   rd_data_a, rd_data_b   : registered read data
//   rd_valid_a, rd_valid_b : data captured at the most recent edge
module regfile_read_2p
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid_a,
  output logic              rd_valid_b
);

  word_t [NUM_IDX-1:0] mem_view;
  logic  [NUM_IDX-1:0] readable;

  // Every encodable index gets a slot in mem_view so the read mux needs no
  // range compare; indices without storage are tied to zero.
  for (genvar i = 0; i < NUM_IDX; i++) begin : g_idx
    if (is_storage(i)) begin : g_entry
      word_t q;

      // NOTE: the storage is built from individual flops, so it can and does
      // take the asynchronous reset like any other state.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (wr_en && (wr_addr == reg_idx_t'(i))) begin
          q <= wr_data;
        end
      end

      assign mem_view[i] = q;
      assign readable[i] = 1'b1;
    end else begin : g_none
      assign mem_view[i] = '0;
      assign readable[i] = 1'b0;
    end
  end

  regfile_rd_port u_port_a (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mem_view (mem_view),
    .readable (readable),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a)
  );

  regfile_rd_port u_port_b (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mem_view (mem_view),
    .readable (readable),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b)
  );

endmodule

// File: tb/tb_regfile_read_2p.sv
// Directed and randomised check of regfile_read_2p against hand-computed
// constants and a small reference model of the register file.
module tb_regfile_read_2p;
  import regfile_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     wr_en;
  reg_idx_t wr_addr;
  word_t    wr_data;
  logic     rd_en_a, rd_en_b;
  reg_idx_t rd_addr_a, rd_addr_b;
  word_t    rd_data_a, rd_data_b;
  logic     rd_valid_a, rd_valid_b;

  int total = 0;
  int bad   = 0;

  word_t model [DEPTH];
  word_t exp_a, exp_b;
  logic  expv_a, expv_b;

  always #5 clk = ~clk;

  regfile_read_2p dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en_a    (rd_en_a),
    .rd_addr_a  (rd_addr_a),
    .rd_en_b    (rd_en_b),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .rd_valid_a (rd_valid_a),
    .rd_valid_b (rd_valid_b)
  );

  task automatic check(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compute model expectations for the current inputs, clock once, compare.
  task automatic model_cycle(input string tag);
    if (rd_en_a) begin
      if (int'(rd_addr_a) == ZERO_REG)             exp_a = '0;
      else if (wr_en && wr_addr == rd_addr_a)      exp_a = wr_data;
      else                                         exp_a = model[rd_addr_a];
    end
    if (rd_en_b) begin
      if (int'(rd_addr_b) == ZERO_REG)             exp_b = '0;
      else if (wr_en && wr_addr == rd_addr_b)      exp_b = wr_data;
      else                                         exp_b = model[rd_addr_b];
    end
    expv_a = rd_en_a;
    expv_b = rd_en_b;
    if (wr_en && int'(wr_addr) != ZERO_REG) model[wr_addr] = wr_data;
    tick();
    check({tag, "_data_a"},  rd_data_a, exp_a);
    check({tag, "_data_b"},  rd_data_b, exp_b);
    check({tag, "_valid_a"}, word_t'(rd_valid_a), word_t'(expv_a));
    check({tag, "_valid_b"}, word_t'(rd_valid_b), word_t'(expv_b));
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hFFFF;
    rd_en_a = 1'b1; rd_addr_a = 5'd5;
    rd_en_b = 1'b1; rd_addr_b = 5'd5;
    #1;
    tick(); tick();
    // Held in reset with every enable high: nothing moves.
    check("rst_hold_data_a",  rd_data_a, '0);
    check("rst_hold_valid_a", word_t'(rd_valid_a), '0);
    check("rst_hold_data_b",  rd_data_b, '0);
    check("rst_hold_valid_b", word_t'(rd_valid_b), '0);
    reset = 1'b0;
    rd_en_a = 1'b0; rd_en_b = 1'b0;

    // 1: write X5, read it, then async reset clears it mid-cycle.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF;
    tick();
    wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 5'd5;
    tick();
    check("t1_read_x5", rd_data_a, 64'hDEAD_BEEF);
    #2 reset = 1'b1;
    #1;
    check("t1_async_data_a",  rd_data_a, '0);
    check("t1_async_valid_a", word_t'(rd_valid_a), '0);
    tick();
    reset = 1'b0;
    tick();
    check("t1_x5_cleared", rd_data_a, '0);
    check("t1_valid_a",    word_t'(rd_valid_a), 64'd1);

    // 2: basic write then read, one edge of latency.
    rd_en_a = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h0123_4567_89AB_CDEF;
    tick();
    check("t2_no_valid_yet", word_t'(rd_valid_a), '0);
    wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 5'd3;
    tick();
    check("t2_read_x3",  rd_data_a, 64'h0123_4567_89AB_CDEF);
    check("t2_valid_a",  word_t'(rd_valid_a), 64'd1);

    // 3: same-edge bypass on both ports; old X7 never appears.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h99;
    rd_en_a = 1'b0;
    tick();
    wr_data = 64'h55;
    rd_en_a = 1'b1; rd_addr_a = 5'd7;
    rd_en_b = 1'b1; rd_addr_b = 5'd7;
    tick();
    check("t3_bypass_a", rd_data_a, 64'h55);
    check("t3_bypass_b", rd_data_b, 64'h55);
    wr_en = 1'b0;
    tick();
    check("t3_stored_a", rd_data_a, 64'h55);

    // 4: XZR reads zero, including when written on the same edge.
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
    rd_en_a = 1'b0;
    rd_en_b = 1'b1; rd_addr_b = 5'd31;
    tick();
    check("t4_zero_b_same_edge", rd_data_b, '0);
    check("t4_valid_b",          word_t'(rd_valid_b), 64'd1);
    wr_en = 1'b0; rd_en_a = 1'b1; rd_addr_a = 5'd31;
    tick();
    check("t4_zero_a", rd_data_a, '0);

    // 5: stalled port B holds across a write to its index.
    rd_en_a = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h10;
    rd_en_b = 1'b0;
    tick();
    wr_en = 1'b0; rd_en_b = 1'b1; rd_addr_b = 5'd2;
    tick();
    check("t5_read_x2", rd_data_b, 64'h10);
    rd_en_b = 1'b0;
    wr_en = 1'b1; wr_data = 64'h20;
    tick();
    check("t5_hold_data",  rd_data_b, 64'h10);
    check("t5_hold_valid", word_t'(rd_valid_b), '0);
    wr_en = 1'b0;
    tick();
    check("t5_hold_data2", rd_data_b, 64'h10);
    rd_en_b = 1'b1;
    tick();
    check("t5_refresh_data",  rd_data_b, 64'h20);
    check("t5_refresh_valid", word_t'(rd_valid_b), 64'd1);

    // 6: clean reset, sweep every index, then random traffic against the model.
    rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0;
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_a = '0; exp_b = '0;
    for (int i = 0; i <= 30; i++) begin
      wr_en = 1'b1; wr_addr = reg_idx_t'(i); wr_data = word_t'(i) * 64'h1111;
      model_cycle("sweep_wr");
    end
    wr_en = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_en_a = 1'b1; rd_addr_a = reg_idx_t'(k);
      rd_en_b = 1'b1; rd_addr_b = reg_idx_t'(DEPTH - 1 - k);
      tick();
      check("sweep_a", rd_data_a, (k == 31) ? '0 : word_t'(k) * 64'h1111);
      check("sweep_b", rd_data_b, (k == 0)  ? '0 : word_t'(31 - k) * 64'h1111);
    end
    exp_a = '0; exp_b = '0;

    for (int n = 0; n < 10000; n++) begin
      wr_en     = 1'($urandom_range(1, 0));
      wr_addr   = reg_idx_t'($urandom_range(31, 0));
      wr_data   = {$urandom, $urandom};
      rd_en_a   = 1'($urandom_range(1, 0));
      rd_addr_a = reg_idx_t'($urandom_range(31, 0));
      rd_en_b   = 1'($urandom_range(1, 0));
      rd_addr_b = ($urandom_range(3, 0) == 0) ? rd_addr_a
                                              : reg_idx_t'($urandom_range(31, 0));
      if ($urandom_range(3, 0) == 0) wr_addr = rd_addr_a;
      model_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
